blast_sprite_draw: RTL and testbench

Animated-sprite overlay stage for the VGA pipeline (e.g. mine-explosion effect). On a `start` pulse it latches a screen position, runs the 60 Hz animation controller through its `trigger` input, and converts that controller's free-running `frame_num` into a local frame index. It then overlays the matching frame from an external sprite ROM onto the pixel stream, with a fixed two-cycle latency. It sits downstream of the animation controller and between two stages of the VGA draw chain.

---
 rtl/blast_sprite_draw.sv | 156 +++++++++++++++
 tb/tb_blast_sprite_draw.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/blast_sprite_draw.sv
// Animated sprite overlay: plays one NUM_FRAMES-long animation per start and
// keys the matching ROM frame over the VGA stream with a fixed 2-cycle latency.
module blast_sprite_draw #(
  parameter int          SPRITE_SIZE = 16,
  parameter int          NUM_FRAMES  = 8,
  parameter int          ADDR_W      = 11,
  parameter logic [11:0] COLOR_KEY   = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       x_pos,
  input  logic [10:0]       y_pos,
  input  logic [3:0]        frame_num,
  output logic              anim_run,
  output logic              busy,
  output logic              done,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data
);
  localparam logic [3:0]  NF   = 4'(NUM_FRAMES);
  localparam logic [3:0]  LAST = 4'(NUM_FRAMES - 1);
  localparam logic [11:0] SS12 = 12'(SPRITE_SIZE);

  typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;
  state_t state;

  logic [10:0] x_q, y_q;
  logic [3:0]  base, disp_frame, rel;

  logic [10:0] hcount_d1, vcount_d1;
  logic        hsync_d1, vsync_d1, hblnk_d1, vblnk_d1, hit_d1;
  logic [11:0] rgb_d1;

  // Controller frame count relative to the start, modulo 16 so a wrapping
  // controller counter still yields a monotonic index.
  assign rel = frame_num - base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      anim_run   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      base       <= '0;
      disp_frame <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= PLAY;
          anim_run   <= 1'b1;
          busy       <= 1'b1;
          x_q        <= x_pos;
          y_q        <= y_pos;
          base       <= frame_num;
          disp_frame <= '0;
        end
        PLAY: begin
          if (rel == NF) begin
            state    <= FINISH;
            anim_run <= 1'b0;
            done     <= 1'b1;
          end
          // Frame switch only at vertical blank start to avoid tearing.
          if (vblnk_in && !vblnk_d1)
            disp_frame <= (rel > LAST) ? LAST : rel;
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: box test at 12 bits so x+SPRITE_SIZE cannot wrap.
  logic [11:0]       h12, v12, x12, y12, dx, dy;
  logic              inbox, hit1;
  logic [ADDR_W-1:0] addr1;

  always_comb begin
    h12   = {1'b0, hcount_in};
    v12   = {1'b0, vcount_in};
    x12   = {1'b0, x_q};
    y12   = {1'b0, y_q};
    dx    = h12 - x12;
    dy    = v12 - y12;
    inbox = (h12 >= x12) && (h12 < x12 + SS12) && (v12 >= y12) && (v12 < y12 + SS12);
    hit1  = inbox && (state == PLAY) && !hblnk_in && !vblnk_in;
    addr1 = ADDR_W'(32'(disp_frame) * 32'(SPRITE_SIZE * SPRITE_SIZE)
                  + 32'(dy) * 32'(SPRITE_SIZE) + 32'(dx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_d1 <= '0;
      vcount_d1 <= '0;
      hsync_d1  <= 1'b0;
      vsync_d1  <= 1'b0;
      hblnk_d1  <= 1'b0;
      vblnk_d1  <= 1'b0;
      rgb_d1    <= '0;
      hit_d1    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      hcount_d1 <= hcount_in;
      vcount_d1 <= vcount_in;
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
      hblnk_d1  <= hblnk_in;
      vblnk_d1  <= vblnk_in;
      rgb_d1    <= rgb_in;
      hit_d1    <= hit1;
      rom_addr  <= hit1 ? addr1 : '0;
    end
  end

  // Stage 2: ROM data returns combinationally against the registered address.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d1;
      vcount_out <= vcount_d1;
      hsync_out  <= hsync_d1;
      vsync_out  <= vsync_d1;
      hblnk_out  <= hblnk_d1;
      vblnk_out  <= vblnk_d1;
      rgb_out    <= (hit_d1 && rom_data != COLOR_KEY) ? rom_data : rgb_d1;
    end
  end
endmodule

// File: tb/tb_blast_sprite_draw.sv
module tb_blast_sprite_draw;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [10:0] x_pos = '0, y_pos = '0;
  logic [3:0]  frame_num = '0;
  logic        anim_run, busy, done;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [10:0] rom_addr;
  logic [11:0] rom_data;
  logic        rom_zero = 1'b0;

  blast_sprite_draw dut (
    .clk(clk), .rst(rst), .start(start), .x_pos(x_pos), .y_pos(y_pos),
    .frame_num(frame_num), .anim_run(anim_run), .busy(busy), .done(done),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  assign rom_data = rom_zero ? 12'h000 : {1'b0, rom_addr};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [37:0] val;
    string       nm;
  } exp_t;
  exp_t q[$];
  int nchk = 0, npass = 0;

  function automatic logic [37:0] actual(int k);
    case (k)
      0:       return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
      1:       return 38'({anim_run, busy, done});
      default: return 38'(rom_addr);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        nchk++;
        if (actual(q[i].kind) === q[i].val) npass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", q[i].nm, cyc, actual(q[i].kind), q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic ex(input int off, input int kind, input logic [37:0] val, input string nm);
    exp_t e;
    e.due = cyc + off; e.kind = kind; e.val = val; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drv(input logic [10:0] h, v, input logic hs, vs, hb, vb, input logic [11:0] rgb);
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    @(posedge clk); #1;
  endtask

  task automatic px(input logic [10:0] h, v, input logic hs, vs, hb, vb,
                    input logic [11:0] rgb, exp_rgb, input string nm);
    ex(2, 0, {h, v, hs, vs, hb, vb, exp_rgb}, nm);
    drv(h, v, hs, vs, hb, vb, rgb);
  endtask

  task automatic dp(input logic [10:0] h, v, input logic [11:0] rgb, exp_rgb, input string nm);
    px(h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb, exp_rgb, nm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x_pos = 11'($urandom); y_pos = 11'($urandom); frame_num = 4'($urandom);
      drv(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 12'($urandom));
    end
    nchk++;
    if (anim_run === 1'b0 && busy === 1'b0 && done === 1'b0 && rom_addr === 11'd0) npass++;
    else $display("FAIL direct_rst anim_run=%b busy=%b done=%b rom_addr=%h", anim_run, busy, done, rom_addr);
    ex(0, 1, 38'd0, "rst_ctrl");
    ex(0, 2, 38'd0, "rst_addr");
    ex(0, 0, 38'd0, "rst_bus");
    rst = 1'b0; start = 1'b0;
    ex(1, 1, 38'd0, "rst_start_ignored");
    dp(11'd0, 11'd0, 12'h000, 12'h000, "post_rst");

    for (int h = 0; h < 1024; h++)
      px(11'(h), 11'd7, h[3], h[5], (h >= 800), 1'b0, 12'(h), 12'(h), "pass");

    frame_num = 4'd14; x_pos = 11'd100; y_pos = 11'd50; start = 1'b1;
    ex(1, 1, 38'b110, "start_ctrl");
    dp(11'd0, 11'd0, 12'h111, 12'h111, "start_px");
    start = 1'b0;
    nchk++;
    if (anim_run === 1'b1 && busy === 1'b1) npass++;
    else $display("FAIL direct_start anim_run=%b busy=%b", anim_run, busy);
    ex(1, 2, 38'd37, "addr37");
    dp(11'd105, 11'd52, 12'hABC, 12'h025, "hit37");
    ex(1, 2, 38'd0, "addr_right_edge");
    dp(11'd116, 11'd52, 12'hABC, 12'hABC, "right_edge_pass");
    ex(1, 2, 38'd255, "addr255");
    dp(11'd115, 11'd65, 12'h123, 12'h0FF, "corner_hit");
    dp(11'd100, 11'd50, 12'h456, 12'h456, "key_pixel_pass");
    dp(11'd99, 11'd50, 12'h789, 12'h789, "left_edge_pass");
    dp(11'd105, 11'd66, 12'h246, 12'h246, "bottom_edge_pass");
    px(11'd105, 11'd52, 1'b0, 1'b0, 1'b1, 1'b0, 12'hABC, 12'hABC, "hblnk_pass");
    rom_zero = 1'b1;
    dp(11'd105, 11'd52, 12'h321, 12'h321, "rom_key_pass");
    dp(11'd0, 11'd0, 12'h654, 12'h654, "rom_key_idle");
    rom_zero = 1'b0;

    x_pos = 11'd300; y_pos = 11'd300; start = 1'b1;
    ex(1, 1, 38'b110, "busy_ignore_ctrl");
    dp(11'd0, 11'd0, 12'h111, 12'h111, "busy_start_px");
    start = 1'b0;
    ex(1, 2, 38'd37, "pos_kept_addr");
    dp(11'd105, 11'd52, 12'hABC, 12'h025, "pos_kept");

    frame_num = 4'd15; dp(11'd0, 11'd0, 12'h111, 12'h111, "f15");
    frame_num = 4'd0;  dp(11'd0, 11'd0, 12'h111, 12'h111, "f0");
    frame_num = 4'd1;
    dp(11'd105, 11'd52, 12'hABC, 12'h025, "no_vblnk_edge_yet");
    px(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777, 12'h777, "vblnk_px");
    ex(1, 2, 38'd805, "addr_frame3");
    dp(11'd105, 11'd52, 12'hABC, 12'h325, "hit_frame3");

    frame_num = 4'd6;
    ex(1, 1, 38'b011, "done_pulse");
    ex(2, 1, 38'd0, "busy_drop");
    ex(3, 1, 38'd0, "single_done");
    ex(1, 2, 38'd805, "last_play_addr");
    dp(11'd105, 11'd52, 12'hABC, 12'h325, "last_play_hit");
    nchk++;
    if (done === 1'b1 && anim_run === 1'b0) npass++;
    else $display("FAIL direct_done done=%b anim_run=%b", done, anim_run);
    ex(1, 2, 38'd0, "finish_addr");
    dp(11'd105, 11'd52, 12'hABC, 12'hABC, "finish_no_draw");
    dp(11'd0, 11'd0, 12'h111, 12'h111, "idle1");
    dp(11'd0, 11'd0, 12'h111, 12'h111, "idle2");

    frame_num = 4'd2; x_pos = 11'd10; y_pos = 11'd20; start = 1'b1;
    ex(1, 1, 38'b110, "start2_ctrl");
    dp(11'd0, 11'd0, 12'h111, 12'h111, "start2_px");
    start = 1'b0;
    frame_num = 4'd3; dp(11'd0, 11'd0, 12'h111, 12'h111, "f3");
    frame_num = 4'd4;
    ex(1, 2, 38'd18, "mid_addr");
    drv(11'd12, 11'd21, 1'b0, 1'b0, 1'b0, 1'b0, 12'h999);
    rst = 1'b1;
    ex(1, 1, 38'd0, "mid_rst_ctrl");
    ex(1, 2, 38'd0, "mid_rst_addr");
    ex(1, 0, 38'd0, "mid_rst_bus");
    drv(11'd12, 11'd21, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
    nchk++;
    if (anim_run === 1'b0 && busy === 1'b0 && done === 1'b0) npass++;
    else $display("FAIL direct_mid_rst anim_run=%b busy=%b done=%b", anim_run, busy, done);
    rst = 1'b0;
    ex(1, 0, 38'd0, "pipe_cleared");
    ex(1, 1, 38'd0, "no_done_after_rst");
    ex(2, 1, 38'd0, "no_done_after_rst2");
    dp(11'd12, 11'd21, 12'h222, 12'h222, "overlay_absent");
    frame_num = 4'd10;
    for (int i = 0; i < 4; i++) dp(11'd12, 11'd21, 12'h333, 12'h333, "idle_tail");

    repeat (4) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      nchk++;
      $display("FAIL unchecked_%s due=%0d got=none exp=%h", q[0].nm, q[0].due, q[0].val);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
